// File: rtl/tl_xbar_ctrl.sv
// ---------------------------------------------------------------------------
// tl_xbar_ctrl
//
// TileLink-UL crossbar between N_MASTERS upstream masters and N_SLAVES
// downstream slaves over one shared channel.
//
// Operation:
// - A round-robin arbiter grants one master at a time.
// - The granted master's single A beat is routed to the slave selected by
//   a_address[SEL_LSB +: SEL_W]. The slave sees the address with the select
//   field cleared.
// - Ownership is held until the matching D beat completes.
// - The crossbar answers locally with d_denied=1 in two cases:
//   - the select field addresses a slave that does not exist;
//   - the slave does not answer within TIMEOUT cycles (TIMEOUT=0 disables
//     this check).
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   master_a_*          A channel from each master (flattened, indexed by master)
//   master_a_ready      A ready back to each master
//   master_d_*          D channel to each master
//   master_d_ready      D ready from each master
//   slave_a_*           A channel to each slave (flattened, indexed by slave)
//   slave_a_ready       A ready from each slave
//   slave_d_*           D channel from each slave
//   slave_d_ready       D ready to each slave
//   grant               one-hot current owner, 0 when idle
//   busy                high whenever a transaction is in flight
//   err_count           saturating count of locally generated denied responses
// ---------------------------------------------------------------------------
module tl_xbar_ctrl #(
    parameter int N_MASTERS = 16,
    parameter int N_SLAVES  = 64,
    parameter int SEL_LSB   = 24,
    parameter int SEL_W     = 6,
    parameter int TIMEOUT   = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    // master side
    input  logic [N_MASTERS-1:0]          master_a_valid,
    input  logic [N_MASTERS-1:0][2:0]     master_a_opcode,
    input  logic [N_MASTERS-1:0][2:0]     master_a_param,
    input  logic [N_MASTERS-1:0][2:0]     master_a_size,
    input  logic [N_MASTERS-1:0][3:0]     master_a_source,
    input  logic [N_MASTERS-1:0][63:0]    master_a_address,
    input  logic [N_MASTERS-1:0][7:0]     master_a_mask,
    input  logic [N_MASTERS-1:0][63:0]    master_a_data,
    input  logic [N_MASTERS-1:0]          master_a_corrupt,
    output logic [N_MASTERS-1:0]          master_a_ready,
    output logic [N_MASTERS-1:0]          master_d_valid,
    output logic [N_MASTERS-1:0][2:0]     master_d_opcode,
    output logic [N_MASTERS-1:0][1:0]     master_d_param,
    output logic [N_MASTERS-1:0][2:0]     master_d_size,
    output logic [N_MASTERS-1:0][3:0]     master_d_source,
    output logic [N_MASTERS-1:0][5:0]     master_d_sink,
    output logic [N_MASTERS-1:0]          master_d_denied,
    output logic [N_MASTERS-1:0][63:0]    master_d_data,
    output logic [N_MASTERS-1:0]          master_d_corrupt,
    input  logic [N_MASTERS-1:0]          master_d_ready,
    // slave side
    output logic [N_SLAVES-1:0]           slave_a_valid,
    output logic [N_SLAVES-1:0][2:0]      slave_a_opcode,
    output logic [N_SLAVES-1:0][2:0]      slave_a_param,
    output logic [N_SLAVES-1:0][2:0]      slave_a_size,
    output logic [N_SLAVES-1:0][3:0]      slave_a_source,
    output logic [N_SLAVES-1:0][63:0]     slave_a_address,
    output logic [N_SLAVES-1:0][7:0]      slave_a_mask,
    output logic [N_SLAVES-1:0][63:0]     slave_a_data,
    output logic [N_SLAVES-1:0]           slave_a_corrupt,
    input  logic [N_SLAVES-1:0]           slave_a_ready,
    input  logic [N_SLAVES-1:0]           slave_d_valid,
    input  logic [N_SLAVES-1:0][2:0]      slave_d_opcode,
    input  logic [N_SLAVES-1:0][1:0]      slave_d_param,
    input  logic [N_SLAVES-1:0][2:0]      slave_d_size,
    input  logic [N_SLAVES-1:0][3:0]      slave_d_source,
    input  logic [N_SLAVES-1:0][5:0]      slave_d_sink,
    input  logic [N_SLAVES-1:0]           slave_d_denied,
    input  logic [N_SLAVES-1:0][63:0]     slave_d_data,
    input  logic [N_SLAVES-1:0]           slave_d_corrupt,
    output logic [N_SLAVES-1:0]           slave_d_ready,
    // status
    output logic [N_MASTERS-1:0]          grant,
    output logic                          busy,
    output logic [15:0]                   err_count
);

    localparam int MIDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam logic [63:0] SEL_MASK = ((64'd1 << SEL_W) - 64'd1) << SEL_LSB;
    localparam logic [2:0] OP_GET       = 3'd4;
    localparam logic [2:0] OP_ACK       = 3'd0;
    localparam logic [2:0] OP_ACK_DATA  = 3'd1;

    typedef enum logic [1:0] {IDLE, ADDR, RESP, ERR} state_t;

    state_t               state, state_next;
    logic [N_MASTERS-1:0] grant_next;
    logic [MIDX_W-1:0]    owner, owner_next;
    logic [MIDX_W-1:0]    ptr, ptr_next;
    logic [SEL_W-1:0]     sel_q, sel_next;
    logic [3:0]           src_q, src_next;
    logic [2:0]           op_q, op_next;
    logic [2:0]           size_q, size_next;
    logic [15:0]          tcnt, tcnt_next;
    logic                 err_first, err_first_next;
    logic [15:0]          err_count_next;

    logic [63:0]          own_addr;
    logic [SEL_W-1:0]     sel_a;
    logic                 sel_ok;
    logic [63:0]          chip_addr;
    logic                 pick_found;
    logic [MIDX_W-1:0]    pick_idx;
    logic [MIDX_W:0]      cand;
    logic                 a_rdy;
    logic                 d_vld;
    logic                 release_own;

    // Decode of the owner's A beat; only meaningful while in ADDR.
    assign own_addr  = master_a_address[owner];
    assign sel_a     = own_addr[SEL_LSB +: SEL_W];
    assign sel_ok    = int'(sel_a) < N_SLAVES;
    assign chip_addr = own_addr & ~SEL_MASK;
    assign busy      = (state != IDLE);

    // Round-robin pick: scan the request vector starting at ptr and wrap
    // once, so the most recently served master becomes lowest priority.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            cand = {1'b0, ptr} + (MIDX_W+1)'(i);
            if (cand >= (MIDX_W+1)'(N_MASTERS)) begin
                cand = cand - (MIDX_W+1)'(N_MASTERS);
            end
            if (!pick_found && master_a_valid[cand[MIDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[MIDX_W-1:0];
            end
        end
    end

    // Next-state and channel routing. Everything defaults to idle/zero so
    // non-owners and unselected slaves always see a quiet channel.
    always_comb begin
        state_next       = state;
        grant_next       = grant;
        owner_next       = owner;
        ptr_next         = ptr;
        sel_next         = sel_q;
        src_next         = src_q;
        op_next          = op_q;
        size_next        = size_q;
        tcnt_next        = tcnt;
        err_first_next   = err_first;
        err_count_next   = err_count;
        a_rdy            = 1'b0;
        d_vld            = 1'b0;
        release_own      = 1'b0;

        master_a_ready   = '0;
        master_d_valid   = '0;
        master_d_opcode  = '0;
        master_d_param   = '0;
        master_d_size    = '0;
        master_d_source  = '0;
        master_d_sink    = '0;
        master_d_denied  = '0;
        master_d_data    = '0;
        master_d_corrupt = '0;
        slave_a_valid    = '0;
        slave_a_opcode   = '0;
        slave_a_param    = '0;
        slave_a_size     = '0;
        slave_a_source   = '0;
        slave_a_address  = '0;
        slave_a_mask     = '0;
        slave_a_data     = '0;
        slave_a_corrupt  = '0;
        slave_d_ready    = '0;

        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_next           = '0;
                    grant_next[pick_idx] = 1'b1;
                    owner_next           = pick_idx;
                    state_next           = ADDR;
                end
            end

            ADDR: begin
                if (master_a_valid[owner]) begin
                    if (!sel_ok) begin
                        // Unmapped: the beat is consumed locally in ERR.
                        sel_next       = sel_a;
                        src_next       = master_a_source[owner];
                        op_next        = master_a_opcode[owner];
                        size_next      = master_a_size[owner];
                        err_first_next = 1'b1;
                        state_next     = ERR;
                    end else begin
                        for (int s = 0; s < N_SLAVES; s++) begin
                            if (sel_a == SEL_W'(s)) begin
                                slave_a_valid[s]   = 1'b1;
                                slave_a_opcode[s]  = master_a_opcode[owner];
                                slave_a_param[s]   = master_a_param[owner];
                                slave_a_size[s]    = master_a_size[owner];
                                slave_a_source[s]  = master_a_source[owner];
                                slave_a_address[s] = chip_addr;
                                slave_a_mask[s]    = master_a_mask[owner];
                                slave_a_data[s]    = master_a_data[owner];
                                slave_a_corrupt[s] = master_a_corrupt[owner];
                                a_rdy              = slave_a_ready[s];
                            end
                        end
                        master_a_ready[owner] = a_rdy;
                        if (a_rdy) begin
                            sel_next   = sel_a;
                            src_next   = master_a_source[owner];
                            op_next    = master_a_opcode[owner];
                            size_next  = master_a_size[owner];
                            tcnt_next  = '0;
                            state_next = RESP;
                        end
                    end
                end
            end

            RESP: begin
                for (int s = 0; s < N_SLAVES; s++) begin
                    if (sel_q == SEL_W'(s)) begin
                        master_d_opcode[owner]  = slave_d_opcode[s];
                        master_d_param[owner]   = slave_d_param[s];
                        master_d_size[owner]    = slave_d_size[s];
                        master_d_source[owner]  = slave_d_source[s];
                        master_d_sink[owner]    = slave_d_sink[s];
                        master_d_denied[owner]  = slave_d_denied[s];
                        master_d_data[owner]    = slave_d_data[s];
                        master_d_corrupt[owner] = slave_d_corrupt[s];
                        slave_d_ready[s]        = master_d_ready[owner];
                        d_vld                   = slave_d_valid[s];
                    end
                end
                master_d_valid[owner] = d_vld;
                tcnt_next = tcnt + 16'd1;
                if (d_vld && master_d_ready[owner]) begin
                    release_own = 1'b1;
                end else if ((TIMEOUT != 0) && (tcnt + 16'd1 == 16'(TIMEOUT))) begin
                    // A already consumed by the slave, so no a_ready in ERR.
                    err_first_next = 1'b0;
                    state_next     = ERR;
                end
            end

            ERR: begin
                master_d_valid[owner]   = 1'b1;
                master_d_denied[owner]  = 1'b1;
                master_d_source[owner]  = src_q;
                master_d_size[owner]    = size_q;
                master_d_opcode[owner]  = (op_q == OP_GET) ? OP_ACK_DATA : OP_ACK;
                master_d_corrupt[owner] = (op_q == OP_GET);
                master_a_ready[owner]   = err_first;
                err_first_next          = 1'b0;
                if (master_d_ready[owner]) begin
                    if (err_count != 16'hFFFF) begin
                        err_count_next = err_count + 16'd1;
                    end
                    release_own = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Release drops ownership and moves the round-robin pointer past
        // the owner so it cannot win the next arbitration over a waiter.
        if (release_own) begin
            grant_next = '0;
            ptr_next   = (owner == MIDX_W'(N_MASTERS-1)) ? '0 : owner + MIDX_W'(1);
            state_next = IDLE;
        end
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            owner     <= '0;
            ptr       <= '0;
            sel_q     <= '0;
            src_q     <= '0;
            op_q      <= '0;
            size_q    <= '0;
            tcnt      <= '0;
            err_first <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_next;
            grant     <= grant_next;
            owner     <= owner_next;
            ptr       <= ptr_next;
            sel_q     <= sel_next;
            src_q     <= src_next;
            op_q      <= op_next;
            size_q    <= size_next;
            tcnt      <= tcnt_next;
            err_first <= err_first_next;
            err_count <= err_count_next;
        end
    end

endmodule
